// File: rtl/beam_sum_acc.sv
// Delay-and-sum accumulator: sums CHANNELS signed samples per beam into a registered valid/ready output.
// Optional macro BEAM_SUM_AVG_EN: output the channel mean (sum >>> log2(CHANNELS)) instead of the raw sum.
module beam_sum_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int SUM_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [SUM_WIDTH-1:0]  sum_out,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [7:0]            ch_idx,
  output logic [15:0]           beam_cnt,
  output logic                  ovf,
  output logic                  dbg_state
);

  // Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
  // valid never depends on ready, and sum_out holds steady while sum_valid & !sum_ready.

  localparam int         LOG2_CH = $clog2(CHANNELS);
  localparam logic [7:0] LAST_CH = 8'(CHANNELS - 1);

  typedef enum logic {ACCUM = 1'b0, STALL = 1'b1} state_t;

  logic [SUM_WIDTH-1:0] r_acc;
  logic [7:0]           r_ch_idx;
  logic [SUM_WIDTH-1:0] r_sum_out;
  logic                 r_sum_valid;
  logic [15:0]          r_beam_cnt;
  logic                 r_ovf;

  state_t               w_state;
  logic                 w_din_ready;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_take;
  logic                 w_out_free;
  logic                 w_load;
  logic                 w_ovf_evt;
  logic [SUM_WIDTH-1:0] w_din_ext;
  logic [SUM_WIDTH-1:0] w_total;
  logic [SUM_WIDTH-1:0] w_load_val;

  assign w_last     = (r_ch_idx == LAST_CH);
  assign w_din_ext  = {{(SUM_WIDTH-DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
  assign w_total    = r_acc + w_din_ext;
  assign w_take     = r_sum_valid & sum_ready;
  assign w_out_free = ~r_sum_valid | sum_ready;
  assign w_accept   = din_valid & w_din_ready;
  assign w_load     = w_accept & w_last & w_out_free;
  // Unreachable while the stall logic holds; flags a broken invariant.
  assign w_ovf_evt  = w_accept & w_last & ~w_out_free;

`ifdef BEAM_SUM_AVG_EN
  assign w_load_val = SUM_WIDTH'($signed(w_total) >>> LOG2_CH);
`else
  assign w_load_val = w_total;
`endif

  // The stall is purely combinational: the last channel waits until the output register frees up.
  always_comb begin
    w_state     = ACCUM;
    w_din_ready = 1'b1;
    if (w_last && r_sum_valid && !sum_ready) begin
      w_state     = STALL;
      w_din_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_ch_idx    <= '0;
      r_sum_out   <= '0;
      r_sum_valid <= 1'b0;
      r_beam_cnt  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_acc    <= '0;
          r_ch_idx <= '0;
        end else begin
          r_acc    <= w_total;
          r_ch_idx <= r_ch_idx + 8'd1;
        end
      end
      if (w_load) begin
        r_sum_out   <= w_load_val;
        r_sum_valid <= 1'b1;
      end else if (w_take) begin
        r_sum_valid <= 1'b0;
      end
      if (w_take) begin
        r_beam_cnt <= r_beam_cnt + 16'd1;
      end
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign din_ready = w_din_ready;
  assign sum_out   = r_sum_out;
  assign sum_valid = r_sum_valid;
  assign ch_idx    = r_ch_idx;
  assign beam_cnt  = r_beam_cnt;
  assign ovf       = r_ovf;
  assign dbg_state = w_state;

endmodule

// File: tb/tb_beam_sum_acc.sv
// Directed bench for beam_sum_acc (CHANNELS=8): reset, sums, signed extremes, back-pressure, streaming, mid-group reset.
module tb_beam_sum_acc;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [18:0] sum_out;
  logic        sum_valid;
  logic        sum_ready;
  logic [7:0]  ch_idx;
  logic [15:0] beam_cnt;
  logic        ovf;
  logic        dbg_state;

  int tests;
  int failed;

  beam_sum_acc #(.DATA_WIDTH(16), .CHANNELS(8), .SUM_WIDTH(19)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .ch_idx    (ch_idx),
    .beam_cnt  (beam_cnt),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected loaded value for a raw group sum.
  function automatic logic signed [31:0] expv(input logic signed [31:0] s);
`ifdef BEAM_SUM_AVG_EN
    return s >>> 3;
`else
    return s;
`endif
  endfunction

  // Drive one accepted beat; caller guarantees din_ready is high.
  task automatic beat(input int v);
    din       = 16'(v);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic group_const(input int v);
    for (int i = 0; i < 8; i++) beat(v);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    reset     = 1'b0;
    din       = 16'd5;
    din_valid = 1'b1;
    sum_ready = 1'b1;

    // Reset held 3 clocks with din_valid high
    repeat (3) @(negedge clk);
    check("rst_sum_out",   $signed(sum_out), 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_ch_idx",    ch_idx, 0);
    check("rst_beam_cnt",  beam_cnt, 0);
    check("rst_ovf",       ovf, 0);
    reset     = 1'b1;
    din_valid = 1'b0;
    #1;
    check("rst_din_ready", din_ready, 1);
    @(negedge clk);

    // Sum 1..8, with an idle gap mid-group
    for (int i = 1; i <= 4; i++) beat(i);
    repeat (3) @(negedge clk);
    check("hold_ch_idx", ch_idx, 4);
    check("hold_valid",  sum_valid, 0);
    for (int i = 5; i <= 8; i++) beat(i);
    check("sum36_valid", sum_valid, 1);
    check("sum36_value", $signed(sum_out), expv(36));
    check("sum36_ch",    ch_idx, 0);
    @(negedge clk);
    check("sum36_cnt",   beam_cnt, 1);
    check("sum36_taken", sum_valid, 0);

    // Signed extremes
    group_const(-32768);
    check("min_value", $signed(sum_out), expv(-262144));
    @(negedge clk);
    check("min_cnt", beam_cnt, 2);
    group_const(32767);
    check("max_value", $signed(sum_out), expv(262136));
    @(negedge clk);
    check("max_cnt", beam_cnt, 3);

    // Back-pressure
    sum_ready = 1'b0;
    group_const(3);
    check("bp_first_valid", sum_valid, 1);
    check("bp_first_value", $signed(sum_out), expv(24));
    for (int i = 0; i < 7; i++) beat(5);
    check("bp_ch7",         ch_idx, 7);
    check("bp_held_value",  $signed(sum_out), expv(24));
    din       = 16'd5;
    din_valid = 1'b1;
    #1;
    check("bp_stall_ready", din_ready, 0);
    check("bp_stall_state", dbg_state, 1);
    repeat (2) @(negedge clk);
    check("bp_stall_ch",    ch_idx, 7);
    check("bp_stall_cnt",   beam_cnt, 3);
    check("bp_stall_value", $signed(sum_out), expv(24));
    sum_ready = 1'b1;
    #1;
    check("bp_release_ready", din_ready, 1);
    check("bp_release_state", dbg_state, 0);
    @(negedge clk);
    din_valid = 1'b0;
    check("bp_new_value", $signed(sum_out), expv(40));
    check("bp_new_valid", sum_valid, 1);
    check("bp_new_cnt",   beam_cnt, 4);
    check("bp_new_ch",    ch_idx, 0);
    check("bp_ovf",       ovf, 0);
    @(negedge clk);
    check("bp_drain_cnt",   beam_cnt, 5);
    check("bp_drain_valid", sum_valid, 0);

    // Streaming: 64 groups back to back, din = g - 3c, group sum = 8g - 84
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sum_ready = 1'b1;
    for (int b = 0; b < 512; b++) begin
      check("st_valid", sum_valid, ((b > 0) && (b % 8 == 0)) ? 1 : 0);
      if ((b > 0) && (b % 8 == 0))
        check("st_value", $signed(sum_out), expv(8 * (b / 8 - 1) - 84));
      din       = 16'((b / 8) - 3 * (b % 8));
      din_valid = 1'b1;
      #1;
      check("st_ready", din_ready, 1);
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("st_last_valid", sum_valid, 1);
    check("st_last_value", $signed(sum_out), expv(420));
    @(negedge clk);
    check("st_beam_cnt", beam_cnt, 64);
    check("st_ovf",      ovf, 0);

    // Reset mid-group
    for (int i = 0; i < 3; i++) beat(9);
    check("mid_ch3", ch_idx, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_ch",  ch_idx, 0);
    check("mid_rst_cnt", beam_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    group_const(2);
    check("mid_valid", sum_valid, 1);
    check("mid_value", $signed(sum_out), expv(16));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
